// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a bit-period counter,
// and a single-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shreg, shreg_d;
  logic            done_ok, done_ok_d;
  logic            done_err, done_err_d;
  logic            sync1, s, s_prev;
  logic            start_edge;

  // NOTE: every flop is assigned with <= so all registers update together on the edge;
  // a blocking = here would let later statements see this cycle's new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync1  <= rx_serial;
      s      <= sync1;
      s_prev <= s;
    end
  end

  assign start_edge = s_prev & ~s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      done_ok  <= 1'b0;
      done_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      done_ok  <= done_ok_d;
      done_err <= done_err_d;
    end
  end

  // NOTE: each output of this block gets a default before the case, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    done_ok_d  = 1'b0;
    done_err_d = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (!s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shreg_d   = {s, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d      = '0;
          state_d    = IDLE;
          done_ok_d  = s;
          done_err_d = ~s;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  // Completion is applied one cycle after the stop sample; the consumer's accept in that
  // same cycle frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= done_err;
      overrun   <= 1'b0;
      if (done_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receive stage of the UART datapath; sits directly downstream of the transmit top and consumes its `tx_serial` line.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial input using a single system clock and an internal bit-period counter.
- Presents each byte on a valid/ready handshake and flags framing errors and overruns.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, serial bit rate.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ/BAUD_RATE` (integer division); must be ≥ 4, elaboration error otherwise.
- `HALF` (localparam) = `CLKS_PER_BIT/2`.
- `clk`  in  1  system clock; sole clock, all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_serial`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_ready`  in  1  consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data`  out  8  received byte, stable while `rx_valid` = 1.
- `rx_valid`  out  1  byte available.
- `rx_busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer:** `rx_serial` passes through 2 flops (reset value 1); `s` = second-flop output.
- **Edge detect:** `s_prev` = `s` delayed one cycle (reset value 1). Start edge = `s_prev`=1 and `s`=0.
- **Counter:** `cnt` counts within bit periods; `bit_idx` is 3 bits.
- **IDLE:** on start edge → START, `cnt`←0.
- **START:** `cnt` increments each cycle. At `cnt`=HALF-1:
  - if `s`=0 → DATA, `cnt`←0, `bit_idx`←0;
  - else (glitch) → IDLE.
- **DATA:** at `cnt`=CLKS_PER_BIT-1, shift `s` in at MSB (so LSB-first arrival yields correct byte), `cnt`←0, `bit_idx`++. After the sample with `bit_idx`=7 → STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT-1, sample `s`, then → IDLE.
  - `s`=1 → byte completes.
  - `s`=0 → `frame_err` pulses next cycle; byte discarded.
- **Break handling:** IDLE responds only to a falling edge, so a line held low after an error never re-triggers.
- **Output register rules**, on byte completion:
  - `rx_valid`=0 → load `rx_data`, set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle → old byte accepted, new byte loaded, `rx_valid` stays 1.
  - `rx_valid`=1 and `rx_ready`=0 → new byte dropped, `rx_data` unchanged, `overrun` pulses.
- **Handshake:** with no completion, `rx_valid`&`rx_ready` clears `rx_valid` next cycle. `rx_data` holds its last value after acceptance.
- **Reset:** asserting `rst_n` mid-frame returns to IDLE immediately and zeroes all registers. No partial byte is ever presented.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0; state IDLE, synchronizer flops 1.
- **Latency:** `rx_valid` rises exactly 3 + HALF + 9·CLKS_PER_BIT rising edges after the first edge that samples `rx_serial`=0.
- **Sample points:**
  - start bit at mid-bit;
  - each data bit one full period later (mid-bit);
  - stop bit at mid-stop.
- **Back-to-back frames:** `rx_valid` asserts before the stop bit ends, so back-to-back frames with a one-bit stop are received without loss.
- **Pulse widths:** `frame_err` and `overrun` are exactly one cycle wide, asserted in the same cycle `rx_valid` would have risen.
- **Glitch rejection:** a low pulse shorter than HALF cycles on `s` produces no output and returns to IDLE after HALF cycles.
- **`rx_busy`:** high from the cycle after the start edge until the cycle after the stop sample.

## Test plan
Bench parameters: CLK_FREQ=16_000_000, BAUD_RATE=1_000_000 (CLKS_PER_BIT=16, HALF=8).

1. **Reset:** hold `rst_n`=0 with `rx_serial`=1 → all outputs at reset values. Release, idle 50 cycles → `rx_busy`=0, `rx_valid`=0.
2. **Basic receive:** send 0xA5 with `rx_ready`=0 → `rx_valid` rises 155 cycles after the start-bit sample, `rx_data`=0xA5, held 100 cycles. Pulse `rx_ready` one cycle → `rx_valid`=0 next cycle.
3. **Glitch:** drive `rx_serial` low for 3 cycles → `rx_busy` high ≤ 9 cycles, then IDLE; no `rx_valid`, no `frame_err`.
4. **Framing error and break:** send 0x3C with stop bit 0, then hold the line low for 20 bit times, then high, then send 0x55 →
   - one `frame_err` pulse;
   - `rx_valid` stays 0 through the break;
   - 0x55 received correctly afterwards.
5. **Overrun:** send 0x11 and 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11, one `overrun` pulse at the second completion. Then `rx_ready`=1 → `rx_valid` drops.
6. **Simultaneous completion and reset:**
   - send 0x00 then 0xFF back-to-back with `rx_ready` pulsed exactly at the 0xFF completion cycle → `rx_data`=0xFF, `rx_valid` continuous, no `overrun`;
   - assert `rst_n` during a later frame's bit 4 → outputs at reset values, no byte presented.
